// File: rtl/seg7_frame_decoder.sv
// seg7_frame_decoder: samples three active-low 7-segment digit buses, filters
// glitches, decodes each digit back to its 2-bit char code and tracks which
// rotation of the word "dE1" is on display.
// Optional feature macro: SEG_BAD_COUNT_EN adds the bad_cnt output.
module seg7_frame_decoder #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned STEP_W        = 8
) (
   input  logic              CLOCK_50,
   input  logic              Resetn,
   input  logic              clr,
   input  logic [0:6]        hex2,
   input  logic [0:6]        hex1,
   input  logic [0:6]        hex0,
   output logic              frame_valid,
   output logic [1:0]        char2,
   output logic [1:0]        char1,
   output logic [1:0]        char0,
   output logic              bad_frame,
   output logic [1:0]        rot_idx,
   output logic              word_ok,
   output logic [STEP_W-1:0] steps,
`ifdef SEG_BAD_COUNT_EN
   output logic              err_sticky,
   output logic [7:0]        bad_cnt
`else
   output logic              err_sticky
`endif
);

   localparam int unsigned CNT_W   = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned SEG_W   = 7;
   localparam int unsigned FRAME_W = 3 * SEG_W;

   // Segment patterns in a..g order, active-low
   localparam logic [SEG_W-1:0] SEG_D     = 7'b1000010;
   localparam logic [SEG_W-1:0] SEG_E     = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_ONE   = 7'b1001111;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

   localparam logic [1:0] ROT_NONE = 2'd3;

   // Returns {invalid, code}; unknown patterns read as blank and flag invalid
   function automatic logic [2:0] seg_decode(input logic [SEG_W-1:0] seg);
      logic [2:0] res;
      case (seg)
         SEG_D:     res = 3'b0_00;
         SEG_E:     res = 3'b0_01;
         SEG_ONE:   res = 3'b0_10;
         SEG_BLANK: res = 3'b0_11;
         default:   res = 3'b1_11;
      endcase
      return res;
   endfunction

   logic [FRAME_W-1:0] sample_c;
   logic [FRAME_W-1:0] s;
   logic [FRAME_W-1:0] last_raw;
   logic [CNT_W-1:0]   stab_cnt;
   logic [1:0]         prev_rot;

   logic [2:0] dec2;
   logic [2:0] dec1;
   logic [2:0] dec0;
   logic [1:0] rot_nxt;
   logic       bad_nxt;
   logic       accept;
   logic       both_valid;
   logic       in_order;
   logic       out_of_order;

   assign sample_c = {hex2, hex1, hex0};

   // Decode the filtered sample and classify it against the previous rotation
   always_comb begin
      dec2         = seg_decode(s[FRAME_W-1 -: SEG_W]);
      dec1         = seg_decode(s[2*SEG_W-1 -: SEG_W]);
      dec0         = seg_decode(s[SEG_W-1 -: SEG_W]);
      rot_nxt      = ROT_NONE;
      case ({dec2[1:0], dec1[1:0], dec0[1:0]})
         6'b00_01_10: rot_nxt = 2'd0;
         6'b01_10_00: rot_nxt = 2'd1;
         6'b10_00_01: rot_nxt = 2'd2;
         default:     rot_nxt = ROT_NONE;
      endcase
      bad_nxt      = dec2[2] | dec1[2] | dec0[2];
      accept       = (stab_cnt == CNT_W'(STABLE_CYCLES)) && (s != last_raw);
      both_valid   = (rot_nxt != ROT_NONE) && (prev_rot != ROT_NONE);
      in_order     = both_valid &&
                     (rot_nxt == ((prev_rot == 2'd2) ? 2'd0 : prev_rot + 2'd1));
      out_of_order = both_valid && !in_order;
   end

   // Register the raw buses and count how long they have been unchanged
   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         s        <= '1;
         stab_cnt <= '0;
      end else begin
         s <= sample_c;
         if (sample_c != s) begin
            stab_cnt <= '0;
         end else if (stab_cnt != CNT_W'(STABLE_CYCLES)) begin
            stab_cnt <= stab_cnt + CNT_W'(1);
         end
      end
   end

   // Publish a newly accepted frame; last_raw starts blank so an idle display stays quiet
   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         last_raw    <= '1;
         frame_valid <= 1'b0;
         char2       <= 2'b11;
         char1       <= 2'b11;
         char0       <= 2'b11;
         bad_frame   <= 1'b0;
         rot_idx     <= ROT_NONE;
         word_ok     <= 1'b0;
         prev_rot    <= ROT_NONE;
      end else begin
         frame_valid <= accept;
         if (accept) begin
            last_raw  <= s;
            char2     <= dec2[1:0];
            char1     <= dec1[1:0];
            char0     <= dec0[1:0];
            bad_frame <= bad_nxt;
            rot_idx   <= rot_nxt;
            word_ok   <= (rot_nxt != ROT_NONE);
            prev_rot  <= rot_nxt;
         end
      end
   end

   // Step counter and sticky error; clr overrides same-cycle updates
   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         steps      <= '0;
         err_sticky <= 1'b0;
      end else if (clr) begin
         steps      <= '0;
         err_sticky <= 1'b0;
      end else if (accept) begin
         if (in_order && (steps != {STEP_W{1'b1}})) begin
            steps <= steps + STEP_W'(1);
         end
         if (bad_nxt || out_of_order) begin
            err_sticky <= 1'b1;
         end
      end
   end

`ifdef SEG_BAD_COUNT_EN
   // Saturating count of accepted frames containing an unknown digit
   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         bad_cnt <= '0;
      end else if (clr) begin
         bad_cnt <= '0;
      end else if (accept && bad_nxt && (bad_cnt != 8'hFF)) begin
         bad_cnt <= bad_cnt + 8'(1);
      end
   end
`endif

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Bench for seg7_frame_decoder: directed scenarios plus randomized frames,
// checked against a behavioural model built from the segment table and the
// "dE1" rotation rules. Two instances share inputs (STEP_W=8 and STEP_W=2).
module tb_seg7_frame_decoder;

   localparam int unsigned SC = 4;
   localparam logic [6:0] P_D = 7'b1000010;
   localparam logic [6:0] P_E = 7'b0110000;
   localparam logic [6:0] P_1 = 7'b1001111;
   localparam logic [6:0] P_B = 7'b1111111;
   localparam logic [6:0] P_8 = 7'b0000000;
   localparam logic [20:0] ROT0  = {P_D, P_E, P_1};
   localparam logic [20:0] ROT1  = {P_E, P_1, P_D};
   localparam logic [20:0] ROT2  = {P_1, P_D, P_E};
   localparam logic [20:0] BLANK = {P_B, P_B, P_B};
   localparam logic [20:0] BAD8  = {P_D, P_8, P_1};

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clr;
   logic [0:6] hex2, hex1, hex0;

   logic       frame_valid, bad_frame, word_ok, err_sticky;
   logic [1:0] char2, char1, char0, rot_idx;
   logic [7:0] steps;
   logic       frame_valid2, bad_frame2, word_ok2, err_sticky2;
   logic [1:0] char2_2, char1_2, char0_2, rot_idx2;
   logic [1:0] steps2;
`ifdef SEG_BAD_COUNT_EN
   logic [7:0] bad_cnt, bad_cnt2;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   seg7_frame_decoder #(.STABLE_CYCLES(SC), .STEP_W(8)) u_dut (
      .CLOCK_50(clk), .Resetn(rst_n), .clr(clr),
      .hex2(hex2), .hex1(hex1), .hex0(hex0),
      .frame_valid(frame_valid), .char2(char2), .char1(char1), .char0(char0),
      .bad_frame(bad_frame), .rot_idx(rot_idx), .word_ok(word_ok),
      .steps(steps), .err_sticky(err_sticky)
`ifdef SEG_BAD_COUNT_EN
      , .bad_cnt(bad_cnt)
`endif
   );

   seg7_frame_decoder #(.STABLE_CYCLES(SC), .STEP_W(2)) u_dut2 (
      .CLOCK_50(clk), .Resetn(rst_n), .clr(clr),
      .hex2(hex2), .hex1(hex1), .hex0(hex0),
      .frame_valid(frame_valid2), .char2(char2_2), .char1(char1_2), .char0(char0_2),
      .bad_frame(bad_frame2), .rot_idx(rot_idx2), .word_ok(word_ok2),
      .steps(steps2), .err_sticky(err_sticky2)
`ifdef SEG_BAD_COUNT_EN
      , .bad_cnt(bad_cnt2)
`endif
   );

   // Behavioural model state
   logic [20:0] m_hist[$];
   logic [20:0] m_last;
   logic        m_fv, m_bad, m_wok, m_err;
   logic [1:0]  m_c2, m_c1, m_c0, m_rot;
   int          m_prev, m_steps, m_steps2, m_badcnt;

   function automatic logic [1:0] ref_char(input logic [6:0] p);
      if (p == P_D) return 2'd0;
      if (p == P_E) return 2'd1;
      if (p == P_1) return 2'd2;
      return 2'd3;
   endfunction

   function automatic bit ref_known(input logic [6:0] p);
      return (p == P_D) || (p == P_E) || (p == P_1) || (p == P_B);
   endfunction

   task automatic model_reset();
      m_hist.delete();
      m_hist.push_back(BLANK);
      m_last = BLANK;
      m_fv = 1'b0; m_bad = 1'b0; m_wok = 1'b0; m_err = 1'b0;
      m_c2 = 2'd3; m_c1 = 2'd3; m_c0 = 2'd3; m_rot = 2'd3;
      m_prev = 3; m_steps = 0; m_steps2 = 0; m_badcnt = 0;
   endtask

   // One clock edge of the reference: a frame is taken once the last SC+1 samples agree
   task automatic model_edge(input logic [20:0] smp, input logic c);
      logic [20:0] cur;
      logic [1:0]  ch[3];
      bit          stable;
      bit          bad;
      int          rot;
      cur    = m_hist[$];
      stable = (m_hist.size() == int'(SC + 1));
      foreach (m_hist[i]) if (m_hist[i] != cur) stable = 1'b0;
      m_fv = stable && (cur != m_last);
      if (m_fv) begin
         bad = 1'b0;
         for (int k = 0; k < 3; k++) begin
            logic [6:0] p;
            p     = cur[20 - 7*k -: 7];
            ch[k] = ref_char(p);
            if (!ref_known(p)) bad = 1'b1;
         end
         rot = 3;
         for (int r = 0; r < 3; r++)
            if (ch[0] == 2'(r) && ch[1] == 2'((r + 1) % 3) && ch[2] == 2'((r + 2) % 3)) rot = r;
         m_c2 = ch[0]; m_c1 = ch[1]; m_c0 = ch[2];
         m_bad = bad; m_rot = 2'(rot); m_wok = (rot != 3);
         if (bad) begin
            m_err = 1'b1;
            if (m_badcnt < 255) m_badcnt++;
         end
         if (rot != 3 && m_prev != 3) begin
            if (rot == (m_prev + 1) % 3) begin
               if (m_steps < 255) m_steps++;
               if (m_steps2 < 3) m_steps2++;
            end else begin
               m_err = 1'b1;
            end
         end
         m_prev = rot;
         m_last = cur;
      end
      if (c) begin
         m_steps = 0; m_steps2 = 0; m_err = 1'b0; m_badcnt = 0;
      end
      m_hist.push_back(smp);
      if (m_hist.size() > int'(SC + 1)) void'(m_hist.pop_front());
   endtask

   // Drive one frame value for one clock, advance the model, return on the falling edge
   task automatic step(input logic [20:0] v, input logic c);
      {hex2, hex1, hex0} = v;
      clr = c;
      @(posedge clk);
      model_edge(v, c);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clr   = 1'b0;
      {hex2, hex1, hex0} = BLANK;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      int pulses = 0;
      do_reset();
      tests++; if ({frame_valid, bad_frame, word_ok, err_sticky} !== 4'b0000) begin fails++; $display("FAIL reset_flags: got %b want 0000", {frame_valid, bad_frame, word_ok, err_sticky}); end
      tests++; if ({char2, char1, char0, rot_idx} !== 8'hFF) begin fails++; $display("FAIL reset_codes: got %h want ff", {char2, char1, char0, rot_idx}); end
      tests++; if (steps !== 8'd0) begin fails++; $display("FAIL reset_steps: got %0d want 0", steps); end
      for (int i = 0; i < 10; i++) begin
         step(BLANK, 1'b0);
         if (frame_valid === 1'b1) pulses++;
      end
      tests++; if (pulses !== 0) begin fails++; $display("FAIL reset_blank_pulses: got %0d want 0", pulses); end
   endtask

   task automatic test_first_frame();
      for (int i = 0; i <= int'(SC); i++) begin
         step(ROT0, 1'b0);
         tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL first_early_fv edge %0d: got %b want 0", i, frame_valid); end
      end
      step(ROT0, 1'b0);
      tests++; if (frame_valid !== 1'b1) begin fails++; $display("FAIL first_fv: got %b want 1", frame_valid); end
      tests++; if ({char2, char1, char0} !== 6'b00_01_10) begin fails++; $display("FAIL first_chars: got %b want 000110", {char2, char1, char0}); end
      tests++; if ({rot_idx, word_ok, steps} !== {2'd0, 1'b1, 8'd0}) begin fails++; $display("FAIL first_rot: got rot=%0d ok=%b steps=%0d want 0 1 0", rot_idx, word_ok, steps); end
      step(ROT0, 1'b0);
      tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL first_pulse_width: got %b want 0", frame_valid); end
   endtask

   task automatic test_rotation();
      logic [20:0] seq[3];
      int pulses = 0;
      seq[0] = ROT1; seq[1] = ROT2; seq[2] = ROT0;
      for (int j = 0; j < 3; j++)
         for (int i = 0; i < 10; i++) begin
            step(seq[j], 1'b0);
            if (frame_valid === 1'b1) pulses++;
         end
      tests++; if (pulses !== 3) begin fails++; $display("FAIL rot_pulses: got %0d want 3", pulses); end
      tests++; if (steps !== 8'd3) begin fails++; $display("FAIL rot_steps: got %0d want 3", steps); end
      tests++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL rot_err: got %b want 0", err_sticky); end
   endtask

   task automatic test_glitch();
      int pulses = 0;
      for (int i = 0; i < 3; i++) begin
         step(ROT1, 1'b0);
         if (frame_valid === 1'b1) pulses++;
      end
      for (int i = 0; i < 10; i++) begin
         step(ROT0, 1'b0);
         if (frame_valid === 1'b1) pulses++;
      end
      tests++; if (pulses !== 0) begin fails++; $display("FAIL glitch_pulses: got %0d want 0", pulses); end
      tests++; if ({char2, char1, char0, rot_idx, steps} !== {6'b00_01_10, 2'd0, 8'd3}) begin fails++; $display("FAIL glitch_hold: got %h want %h", {char2, char1, char0, rot_idx, steps}, {6'b00_01_10, 2'd0, 8'd3}); end
   endtask

   task automatic test_bad_frame();
      int pulses = 0;
      for (int i = 0; i < 10; i++) begin
         step(BAD8, 1'b0);
         if (frame_valid === 1'b1) begin
            pulses++;
            tests++; if ({bad_frame, char2, char1, char0} !== {1'b1, 6'b00_11_10}) begin fails++; $display("FAIL bad_decode: got %b want 1001110", {bad_frame, char2, char1, char0}); end
            tests++; if ({rot_idx, word_ok} !== 3'b110) begin fails++; $display("FAIL bad_rot: got %b want 110", {rot_idx, word_ok}); end
            tests++; if (err_sticky !== 1'b1) begin fails++; $display("FAIL bad_err: got %b want 1", err_sticky); end
`ifdef SEG_BAD_COUNT_EN
            tests++; if (bad_cnt !== 8'd1) begin fails++; $display("FAIL bad_cnt: got %0d want 1", bad_cnt); end
`endif
         end
      end
      tests++; if (pulses !== 1) begin fails++; $display("FAIL bad_pulses: got %0d want 1", pulses); end
   endtask

   task automatic test_backward();
      step(BAD8, 1'b1);
      tests++; if ({steps, err_sticky} !== 9'd0) begin fails++; $display("FAIL bwd_clr1: got steps=%0d err=%b want 0 0", steps, err_sticky); end
`ifdef SEG_BAD_COUNT_EN
      tests++; if (bad_cnt !== 8'd0) begin fails++; $display("FAIL bwd_clr_badcnt: got %0d want 0", bad_cnt); end
`endif
      repeat (8) step(ROT1, 1'b0);
      repeat (8) step(ROT2, 1'b0);
      repeat (8) step(ROT1, 1'b0);
      tests++; if ({steps, err_sticky} !== {8'd1, 1'b1}) begin fails++; $display("FAIL bwd_err: got steps=%0d err=%b want 1 1", steps, err_sticky); end
      step(ROT1, 1'b1);
      tests++; if ({steps, err_sticky} !== 9'd0) begin fails++; $display("FAIL bwd_clr2: got steps=%0d err=%b want 0 0", steps, err_sticky); end
      // clr lands on the same edge as an in-order accept
      repeat (5) step(ROT2, 1'b0);
      step(ROT2, 1'b1);
      tests++; if ({frame_valid, rot_idx, steps, err_sticky} !== {1'b1, 2'd2, 8'd0, 1'b0}) begin fails++; $display("FAIL clr_wins: got fv=%b rot=%0d steps=%0d err=%b want 1 2 0 0", frame_valid, rot_idx, steps, err_sticky); end
   endtask

   task automatic test_saturation();
      logic [20:0] seq[6];
      seq[0] = ROT0; seq[1] = ROT1; seq[2] = ROT2;
      seq[3] = ROT0; seq[4] = ROT1; seq[5] = ROT2;
      repeat (7) step(BLANK, 1'b0);
      step(BLANK, 1'b1);
      for (int j = 0; j < 6; j++) repeat (8) step(seq[j], 1'b0);
      tests++; if (steps !== 8'd5) begin fails++; $display("FAIL sat_steps8: got %0d want 5", steps); end
      tests++; if (steps2 !== 2'd3) begin fails++; $display("FAIL sat_steps2: got %0d want 3", steps2); end
      tests++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL sat_err: got %b want 0", err_sticky); end
   endtask

   task automatic test_random();
      logic [20:0] v;
      logic [6:0]  d;
      logic        c;
      int          hold, sel;
      for (int n = 0; n < 250; n++) begin
         sel = int'($urandom_range(0, 9));
         case (sel)
            0, 1: v = ROT0;
            2, 3: v = ROT1;
            4, 5: v = ROT2;
            6:    v = BLANK;
            default: begin
               v = (sel == 7) ? ROT1 : ROT2;
               d = 7'($urandom);
               case ($urandom_range(0, 2))
                  0: v[20:14] = d;
                  1: v[13:7]  = d;
                  default: v[6:0] = d;
               endcase
            end
         endcase
         hold = int'($urandom_range(1, 8));
         for (int i = 0; i < hold; i++) begin
            c = ($urandom_range(0, 31) == 0);
            step(v, c);
            tests++; if ({frame_valid, char2, char1, char0, bad_frame, rot_idx, word_ok, err_sticky} !== {m_fv, m_c2, m_c1, m_c0, m_bad, m_rot, m_wok, m_err}) begin fails++; $display("FAIL rnd_out n=%0d: got %b want %b", n, {frame_valid, char2, char1, char0, bad_frame, rot_idx, word_ok, err_sticky}, {m_fv, m_c2, m_c1, m_c0, m_bad, m_rot, m_wok, m_err}); end
            tests++; if ({frame_valid2, char2_2, char1_2, char0_2, bad_frame2, rot_idx2, word_ok2, err_sticky2} !== {m_fv, m_c2, m_c1, m_c0, m_bad, m_rot, m_wok, m_err}) begin fails++; $display("FAIL rnd_out2 n=%0d: got %b want %b", n, {frame_valid2, char2_2, char1_2, char0_2, bad_frame2, rot_idx2, word_ok2, err_sticky2}, {m_fv, m_c2, m_c1, m_c0, m_bad, m_rot, m_wok, m_err}); end
            tests++; if ({steps, steps2} !== {8'(m_steps), 2'(m_steps2)}) begin fails++; $display("FAIL rnd_steps n=%0d: got %0d/%0d want %0d/%0d", n, steps, steps2, m_steps, m_steps2); end
`ifdef SEG_BAD_COUNT_EN
            tests++; if ({bad_cnt, bad_cnt2} !== {8'(m_badcnt), 8'(m_badcnt)}) begin fails++; $display("FAIL rnd_badcnt n=%0d: got %0d/%0d want %0d", n, bad_cnt, bad_cnt2, m_badcnt); end
`endif
         end
      end
   endtask

   task automatic test_async_reset();
      int pulses = 0;
      repeat (8) step(ROT0, 1'b0);
      repeat (8) step(ROT1, 1'b0);
      repeat (3) step(ROT2, 1'b0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      tests++; if ({frame_valid, bad_frame, word_ok, err_sticky} !== 4'b0000) begin fails++; $display("FAIL async_flags: got %b want 0000", {frame_valid, bad_frame, word_ok, err_sticky}); end
      tests++; if ({char2, char1, char0, rot_idx, steps} !== {8'hFF, 8'd0}) begin fails++; $display("FAIL async_codes: got %h want ff00", {char2, char1, char0, rot_idx, steps}); end
      {hex2, hex1, hex0} = BLANK;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step(BLANK, 1'b0);
         if (frame_valid === 1'b1) pulses++;
      end
      tests++; if (pulses !== 0) begin fails++; $display("FAIL async_blank_pulses: got %0d want 0", pulses); end
      for (int i = 0; i <= int'(SC) + 1; i++) step(ROT2, 1'b0);
      tests++; if ({frame_valid, rot_idx, word_ok, steps} !== {1'b1, 2'd2, 1'b1, 8'd0}) begin fails++; $display("FAIL async_refill: got fv=%b rot=%0d ok=%b steps=%0d want 1 2 1 0", frame_valid, rot_idx, word_ok, steps); end
   endtask

   initial begin
      rst_n = 1'b0;
      clr   = 1'b0;
      {hex2, hex1, hex0} = BLANK;
      @(negedge clk);
      test_reset();
      test_first_frame();
      test_rotation();
      test_glitch();
      test_bad_frame();
      test_backward();
      test_saturation();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
